ps2_keyboard_rx: RTL and testbench

Real PS/2 keyboard receiver that replaces the fake keycode generator. It synchronises and filters PS2C/PS2D, deserialises 11-bit device-to-host frames and folds E0/F0 prefixes into per-key make/break events. Events are buffered in a FIFO that the keypad/display logic drains with a valid/pop handshake.

---
 rtl/ps2_keyboard_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise + filter PS2C/PS2D, deserialise frames, fold E0/F0
// prefixes into make/break events and buffer them in a FIFO. Define PS2_PARITY_CHECK_EN for odd-parity checking.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       key_pop,
    output logic [7:0] key_code_out,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]     ps2cSync_q, ps2dSync_q;
    logic [FCW-1:0] filtCnt_q, filtCnt_d;
    logic           filtClk_q, filtClk_d;
    logic           fall_q, fall_d;
    logic           dataS;

    logic [1:0]     state_q, state_d;
    logic [2:0]     bitCnt_q, bitCnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [WDW-1:0] wdCnt_q, wdCnt_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic           pushValid_q, pushValid_d;
    logic [9:0]     pushData_q, pushData_d;
    logic           frameErr_q, frameErr_d;
    logic           timeout;
    logic           parityOk;
`ifdef PS2_PARITY_CHECK_EN
    logic           parity_q, parity_d;
`endif

    logic [9:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]    wrPtr_q, rdPtr_q;
    logic           fifoFull, fifoEmpty, popEff, pushAccept;
    logic           overflow_q;
    logic [9:0]     head;

    assign dataS = ps2dSync_q[1];

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            ps2cSync_q <= 2'b11;
            ps2dSync_q <= 2'b11;
        end else begin
            ps2cSync_q <= {ps2cSync_q[0], PS2C};
            ps2dSync_q <= {ps2dSync_q[0], PS2D};
        end
    end

    // The filtered clock only follows the synchronised clock after FILTER_LEN differing samples in a row.
    always_comb begin
        filtCnt_d = '0;
        filtClk_d = filtClk_q;
        fall_d    = 1'b0;
        if (ps2cSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
                filtClk_d = ps2cSync_q[1];
                fall_d    = filtClk_q;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            filtCnt_q <= '0;
            filtClk_q <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            filtCnt_q <= filtCnt_d;
            filtClk_q <= filtClk_d;
            fall_q    <= fall_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parityOk = ^{parity_q, shift_q};
`else
    assign parityOk = 1'b1;
`endif

    assign timeout = (state_q != IDLE) && !fall_q && (wdCnt_q == WDW'(TIMEOUT_CYCLES - 1));

    // Frame FSM and prefix decoder share one next-state block so a completed byte is decoded in the same cycle.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        wdCnt_d     = '0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        pushValid_d = 1'b0;
        pushData_d  = pushData_q;
        frameErr_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        if (state_q != IDLE && !fall_q) begin
            wdCnt_d = wdCnt_q + 1'b1;
        end
        if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!dataS) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                        shift_d  = 8'h00;
                    end
                end
                DATA: begin
                    shift_d  = {dataS, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dataS;
`endif
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dataS && parityOk) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            pushValid_d = 1'b1;
                            pushData_d  = {ext_q, brk_q, shift_q};
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                        end
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            endcase
        end else if (timeout) begin
            state_d    = IDLE;
            bitCnt_d   = 3'd0;
            shift_d    = 8'h00;
            frameErr_d = 1'b1;
        end
        if (frameErr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            wdCnt_q     <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            pushValid_q <= 1'b0;
            pushData_q  <= 10'h000;
            frameErr_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            wdCnt_q     <= wdCnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            pushValid_q <= pushValid_d;
            pushData_q  <= pushData_d;
            frameErr_q  <= frameErr_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // A pop while full frees the slot the simultaneous push needs; a pop while empty is ignored.
    assign fifoEmpty  = (wrPtr_q == rdPtr_q);
    assign fifoFull   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign popEff     = key_pop && !fifoEmpty;
    assign pushAccept = pushValid_q && (!fifoFull || popEff);

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushAccept) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popEff) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            overflow_q <= pushValid_q && fifoFull && !popEff;
        end
    end

    always_ff @(posedge ck) begin
        if (pushAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_q;
        end
    end

    assign head         = mem_q[rdPtr_q[AW-1:0]];
    assign key_valid    = !fifoEmpty;
    assign key_code_out = key_valid ? head[7:0] : 8'h00;
    assign key_release  = key_valid ? head[8] : 1'b0;
    assign key_extended = key_valid ? head[9] : 1'b0;
    assign frame_err    = frameErr_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are bit-banged on PS2C/PS2D, expected events queued, popped and compared.
module tb_ps2_keyboard_rx;

    localparam int FL = 4;
    localparam int TO = 300;
    localparam int FD = 4;
    localparam int HP = 20;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       PS2C = 1'b1;
    logic       PS2D = 1'b1;
    logic       key_pop = 1'b0;
    logic [7:0] key_code_out;
    logic       key_valid, key_release, key_extended, frame_err, overflow;

    int checks = 0;
    int failures = 0;
    int errCount = 0;
    int ovCount = 0;
    logic [9:0] expQ[$];

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
        .ck(ck), .reset(reset), .PS2C(PS2C), .PS2D(PS2D), .key_pop(key_pop),
        .key_code_out(key_code_out), .key_valid(key_valid), .key_release(key_release),
        .key_extended(key_extended), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 ck = ~ck;

    // Pulse counters: a one-cycle pulse adds exactly one.
    always @(negedge ck) begin
        if (frame_err === 1'b1) errCount++;
        if (overflow === 1'b1) ovCount++;
    end

    function automatic logic [10:0] frameBits(input logic [7:0] b, input bit flip, input bit badStop);
        logic p;
        p = ~(^b) ^ flip;
        return {~badStop, p, b, 1'b0};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            PS2D = bits[i];
            if (glitch) begin
                waitCycles(8); PS2C = 1'b0; waitCycles(1); PS2C = 1'b1; waitCycles(HP - 9);
            end else begin
                waitCycles(HP);
            end
            PS2C = 1'b0;
            if (glitch) begin
                waitCycles(8); PS2C = 1'b1; waitCycles(1); PS2C = 1'b0; waitCycles(HP - 9);
            end else begin
                waitCycles(HP);
            end
            PS2C = 1'b1;
        end
        PS2D = 1'b1;
        waitCycles(HP);
    endtask

    task automatic sendFrame(input logic [7:0] b);
        sendBits(frameBits(b, 1'b0, 1'b0), 11, 1'b0);
    endtask

    task automatic popHead(output logic [9:0] ev, output logic vld);
        @(negedge ck);
        vld = key_valid;
        ev  = {key_extended, key_release, key_code_out};
        if (vld) key_pop = 1'b1;
        @(negedge ck);
        key_pop = 1'b0;
    endtask

    task automatic test_reset;
        waitCycles(3);
        checks++; if (key_code_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_code got=%h exp=00", key_code_out); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_release !== 1'b0) begin failures++; $display("[TB] FAIL reset_release got=%b exp=0", key_release); end
        checks++; if (key_extended !== 1'b0) begin failures++; $display("[TB] FAIL reset_extended got=%b exp=0", key_extended); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        reset = 1'b0;
        waitCycles(5);
    endtask

    task automatic test_single_make;
        logic [9:0] ev, exp;
        logic vld;
        expQ.push_back({2'b00, 8'h16});
        sendBits(frameBits(8'h16, 1'b0, 1'b0), 10, 1'b0);
        PS2D = 1'b1;
        waitCycles(HP);
        PS2C = 1'b0;
        waitCycles(7);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_early got=%b exp=0", key_valid); end
        waitCycles(1);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid_latency got=%b exp=1", key_valid); end
        waitCycles(HP - 8);
        PS2C = 1'b1;
        waitCycles(HP);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL single_event got vld=%b ev=%h exp=%h", vld, ev, exp); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_empty got=%b exp=0", key_valid); end
    endtask

    task automatic test_ext_break;
        logic [9:0] ev, exp;
        logic vld;
        expQ.push_back({2'b11, 8'h5A});
        sendFrame(8'hE0);
        sendFrame(8'hF0);
        sendFrame(8'h5A);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL ext_break_event got vld=%b ev=%h exp=%h", vld, ev, exp); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL ext_break_single got=%b exp=0", key_valid); end
    endtask

    task automatic test_overflow;
        logic [9:0] ev, exp;
        logic vld;
        logic [7:0] codes [4];
        int ovBefore;
        codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23;
        for (int i = 0; i < FD; i++) begin
            expQ.push_back({2'b00, codes[i]});
            sendFrame(codes[i]);
        end
        ovBefore = ovCount;
        sendFrame(8'h2B);
        checks++; if (ovCount - ovBefore !== 1) begin failures++; $display("[TB] FAIL overflow_pulse got=%0d exp=1", ovCount - ovBefore); end
        for (int i = 0; i < FD; i++) begin
            popHead(ev, vld);
            exp = expQ.pop_front();
            checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL overflow_drain%0d got vld=%b ev=%h exp=%h", i, vld, ev, exp); end
        end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL overflow_empty got=%b exp=0", key_valid); end

        for (int i = 0; i < FD; i++) begin
            expQ.push_back({2'b00, codes[i]});
            sendFrame(codes[i]);
        end
        ovBefore = ovCount;
        sendBits(frameBits(8'h2B, 1'b0, 1'b0), 10, 1'b0);
        PS2D = 1'b1;
        waitCycles(HP);
        PS2C = 1'b0;
        waitCycles(7);
        exp = expQ.pop_front();
        ev  = {key_extended, key_release, key_code_out};
        checks++; if (key_valid !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL popfull_head got vld=%b ev=%h exp=%h", key_valid, ev, exp); end
        key_pop = 1'b1;
        waitCycles(1);
        key_pop = 1'b0;
        expQ.push_back({2'b00, 8'h2B});
        waitCycles(HP);
        PS2C = 1'b1;
        waitCycles(HP);
        checks++; if (ovCount - ovBefore !== 0) begin failures++; $display("[TB] FAIL popfull_no_overflow got=%0d exp=0", ovCount - ovBefore); end
        for (int i = 0; i < FD; i++) begin
            popHead(ev, vld);
            exp = expQ.pop_front();
            checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL popfull_drain%0d got vld=%b ev=%h exp=%h", i, vld, ev, exp); end
        end
    endtask

    task automatic test_frame_errors;
        logic [9:0] ev, exp;
        logic vld;
        int errBefore;
        sendFrame(8'hE0);
        errBefore = errCount;
        sendBits(frameBits(8'h2E, 1'b0, 1'b1), 11, 1'b0);
        checks++; if (errCount - errBefore !== 1) begin failures++; $display("[TB] FAIL bad_stop_err got=%0d exp=1", errCount - errBefore); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL bad_stop_noevent got=%b exp=0", key_valid); end
        expQ.push_back({2'b00, 8'h2E});
        sendFrame(8'h2E);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL bad_stop_flags_cleared got vld=%b ev=%h exp=%h", vld, ev, exp); end

        errBefore = errCount;
`ifdef PS2_PARITY_CHECK_EN
        sendBits(frameBits(8'h1E, 1'b1, 1'b0), 11, 1'b0);
        checks++; if (errCount - errBefore !== 1) begin failures++; $display("[TB] FAIL parity_err got=%0d exp=1", errCount - errBefore); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL parity_noevent got=%b exp=0", key_valid); end
`else
        expQ.push_back({2'b00, 8'h1E});
        sendBits(frameBits(8'h1E, 1'b1, 1'b0), 11, 1'b0);
        checks++; if (errCount - errBefore !== 0) begin failures++; $display("[TB] FAIL parity_ignored_err got=%0d exp=0", errCount - errBefore); end
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL parity_ignored_event got vld=%b ev=%h exp=%h", vld, ev, exp); end
`endif
    endtask

    task automatic test_timeout;
        logic [9:0] ev, exp;
        logic vld;
        int errBefore;
        errBefore = errCount;
        sendBits(frameBits(8'h55, 1'b0, 1'b0), 5, 1'b0);
        waitCycles(TO + 100);
        checks++; if (errCount - errBefore !== 1) begin failures++; $display("[TB] FAIL timeout_err got=%0d exp=1", errCount - errBefore); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL timeout_noevent got=%b exp=0", key_valid); end
        expQ.push_back({2'b00, 8'h26});
        sendFrame(8'h26);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL timeout_recover got vld=%b ev=%h exp=%h", vld, ev, exp); end
    endtask

    task automatic test_glitch_reset;
        logic [9:0] ev, exp;
        logic vld;
        int errBefore;
        expQ.push_back({2'b00, 8'h25});
        sendBits(frameBits(8'h25, 1'b0, 1'b0), 11, 1'b1);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL glitch_event got vld=%b ev=%h exp=%h", vld, ev, exp); end
        sendFrame(8'hF0);
        sendBits(frameBits(8'h25, 1'b0, 1'b0), 6, 1'b1);
        reset = 1'b1;
        waitCycles(3);
        checks++;
        if ({key_code_out, key_valid, key_release, key_extended, frame_err, overflow} !== 13'h0) begin
            failures++;
            $display("[TB] FAIL midframe_reset_outputs got=%h exp=0000", {key_code_out, key_valid, key_release, key_extended, frame_err, overflow});
        end
        reset = 1'b0;
        errBefore = errCount;
        waitCycles(TO + 100);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL midframe_no_event got=%b exp=0", key_valid); end
        checks++; if (errCount - errBefore !== 0) begin failures++; $display("[TB] FAIL midframe_no_err got=%0d exp=0", errCount - errBefore); end
        expQ.push_back({2'b00, 8'h16});
        sendFrame(8'h16);
        popHead(ev, vld);
        exp = expQ.pop_front();
        checks++; if (vld !== 1'b1 || ev !== exp) begin failures++; $display("[TB] FAIL after_reset_event got vld=%b ev=%h exp=%h", vld, ev, exp); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_ext_break();
        test_overflow();
        test_frame_errors();
        test_timeout();
        test_glitch_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
